// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated main/cross phase scheduler; all intervals count the 1 Hz tick enable.
// Optional build macro FLASH_MODE_EN adds flash_req and a blinking FLASH state.
module traffic_phase_scheduler #(
  parameter int MAIN_GREEN_MIN = 15,
  parameter int MAIN_YELLOW    = 3,
  parameter int ALL_RED        = 1,
  parameter int CROSS_GREEN    = 10,
  parameter int CROSS_YELLOW   = 3,
  parameter int WALK_TIME      = 7,
  parameter int CNT_W          = 5
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       tick_1Hz,
  input  logic       cross_sensor,
  input  logic       ped_btn,
`ifdef FLASH_MODE_EN
  input  logic       flash_req,
`endif
  output logic [2:0] main_st,
  output logic [2:0] cross_st,
  output logic       walk,
  output logic       ped_pending
);

  typedef enum logic [2:0] {
    S_MG  = 3'd0,
    S_MY  = 3'd1,
    S_AR1 = 3'd2,
    S_CG  = 3'd3,
    S_CY  = 3'd4,
    S_AR2 = 3'd5
`ifdef FLASH_MODE_EN
    , S_FLASH = 3'd6
`endif
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
`ifdef FLASH_MODE_EN
  localparam logic [2:0] OFF = 3'b000;
`endif

  localparam logic [CNT_W-1:0] MG_LAST  = CNT_W'(MAIN_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] MY_LAST  = CNT_W'(MAIN_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] CG_LAST  = CNT_W'(CROSS_GREEN - 1);
  localparam logic [CNT_W-1:0] CY_LAST  = CNT_W'(CROSS_YELLOW - 1);
  localparam logic [CNT_W-1:0] WALK_LIM = CNT_W'(WALK_TIME);

  state_t             state_q, state_d, nxt;
  logic [CNT_W-1:0]   timer_q, timer_d, last;
  logic               timed;
  logic               ped_q, ped_d;
  logic               grant_q, grant_d;
  logic               cg_entry;
`ifdef FLASH_MODE_EN
  logic               lit_q, lit_d;
`endif

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= S_MG;
      timer_q <= '0;
      ped_q   <= 1'b0;
      grant_q <= 1'b0;
`ifdef FLASH_MODE_EN
      lit_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ped_q   <= ped_d;
      grant_q <= grant_d;
`ifdef FLASH_MODE_EN
      lit_q   <= lit_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    timed   = 1'b0;
    last    = '0;
    nxt     = S_MG;
    case (state_q)
      // Main green rests with a saturated timer until demand shows up on a tick.
      S_MG: begin
        if (tick_1Hz) begin
          if (timer_q == MG_LAST) begin
            if (cross_sensor | ped_q) state_d = S_MY;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      end
      S_MY:  begin timed = 1'b1; last = MY_LAST; nxt = S_AR1; end
      S_AR1: begin timed = 1'b1; last = AR_LAST; nxt = S_CG;  end
      S_CG:  begin timed = 1'b1; last = CG_LAST; nxt = S_CY;  end
      S_CY:  begin timed = 1'b1; last = CY_LAST; nxt = S_AR2; end
      S_AR2: begin timed = 1'b1; last = AR_LAST; nxt = S_MG;  end
`ifdef FLASH_MODE_EN
      S_FLASH: if (!flash_req) state_d = S_AR2;
`endif
      default: state_d = S_MG;
    endcase

    if (timed && tick_1Hz) begin
      if (timer_q == last) state_d = nxt;
      else                 timer_d = timer_q + CNT_W'(1);
    end

`ifdef FLASH_MODE_EN
    if (flash_req) state_d = S_FLASH;
`endif

    if (state_d != state_q) timer_d = '0;

    // A press landing in the CG-entry cycle is served by this green, so it feeds the grant.
    cg_entry = (state_d == S_CG) && (state_q != S_CG);
    ped_d    = cg_entry ? 1'b0 : (ped_q | ped_btn);
    grant_d  = cg_entry ? (ped_q | ped_btn) : grant_q;

`ifdef FLASH_MODE_EN
    if (state_d == S_FLASH || state_q == S_FLASH) ped_d = 1'b0;
    lit_d = lit_q;
    if (state_d == S_FLASH && state_q != S_FLASH) lit_d = 1'b1;
    else if (state_q == S_FLASH && tick_1Hz)      lit_d = ~lit_q;
`endif
  end

  always_comb begin
    main_st  = RED;
    cross_st = RED;
    case (state_q)
      S_MG:  begin main_st = GRN; cross_st = RED; end
      S_MY:  begin main_st = YEL; cross_st = RED; end
      S_AR1: begin main_st = RED; cross_st = RED; end
      S_CG:  begin main_st = RED; cross_st = GRN; end
      S_CY:  begin main_st = RED; cross_st = YEL; end
      S_AR2: begin main_st = RED; cross_st = RED; end
`ifdef FLASH_MODE_EN
      S_FLASH: begin
        main_st  = lit_q ? YEL : OFF;
        cross_st = lit_q ? RED : OFF;
      end
`endif
      default: begin main_st = RED; cross_st = RED; end
    endcase
  end

  assign walk        = (state_q == S_CG) && grant_q && (timer_q < WALK_LIM);
  assign ped_pending = ped_q;

endmodule
